// File: rtl/sub_serial_n_pkg.sv
// Shared types and bit-level helper for the bit-serial subtractor.
// Optional signed overflow flag is enabled by SUB_SIGNED_OVF_EN.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [1:0] full_sub(
    input logic a,
    input logic b,
    input logic br
  );
    return {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction

endpackage

// File: rtl/sub_serial_n_full_sub.sv
// Combinational 1-bit full subtractor: {bo,d} = a - b - br.
module full_sub_1
  import sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign {bo, d} = full_sub(a, b, br);

endmodule

// File: rtl/sub_serial_n.sv
// Bit-serial N-bit subtractor, LSB first, start/done handshake.
// Define SUB_SIGNED_OVF_EN to build the signed overflow flag.
module sub_serial_n
  import sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] P,
  input  logic [N-1:0] Q,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] DIFF,
  output logic         Bout,
  output logic         OVF
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   p_sr_q, p_sr_d;
  logic [N-1:0]   q_sr_q, q_sr_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           bit_d, bit_bo;
  logic [N-1:0]   res_shift;
  logic           enter_done;

  full_sub_1 u_fs (
    .a  (p_sr_q[0]),
    .b  (q_sr_q[0]),
    .br (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  assign res_shift  = {bit_d, res_q[N-1:1]};
  assign enter_done = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    p_sr_d  = p_sr_q;
    q_sr_d  = q_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_sr_d  = P;
          q_sr_d  = Q;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        p_sr_d = p_sr_q >> 1;
        q_sr_d = q_sr_q >> 1;
        res_d  = res_shift;
        br_d   = bit_bo;
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bout_d  = bit_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_sr_q  <= '0;
      q_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_sr_q  <= p_sr_d;
      q_sr_q  <= q_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic pm_q, qm_q, ovf_q;

  // Overflow uses operand MSBs frozen at start, not the live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_q  <= 1'b0;
      qm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        pm_q <= P[N-1];
        qm_q <= Q[N-1];
      end
      if (enter_done)
        ovf_q <= (pm_q != qm_q) && (bit_d != pm_q);
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign DIFF = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_sub_serial_n.sv
// Randomized scoreboard bench for sub_serial_n (N=8).
module tb_sub_serial_n;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] P, Q;
  logic         Bin;
  logic         busy, done, Bout, OVF;
  logic [N-1:0] DIFF;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  sub_serial_n #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .P     (P),
    .Q     (Q),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .DIFF  (DIFF),
    .Bout  (Bout),
    .OVF   (OVF)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(
    input logic [N-1:0] p,
    input logic [N-1:0] q,
    input logic         b,
    input int           acc
  );
    exp_t e;
    int   full;
    full = (int'(p) - int'(q) - int'(b)) & ((1 << (N + 1)) - 1);
    e.d  = full[N-1:0];
    e.bo = full[N];
`ifdef SUB_SIGNED_OVF_EN
    e.ov = (p[N-1] != q[N-1]) && (e.d[N-1] != p[N-1]);
`else
    e.ov = 1'b0;
`endif
    e.cyc = acc + N;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(DIFF), 32'(e.d));
        chk("bout", 32'(Bout), 32'(e.bo));
        chk("ovf", 32'(OVF), 32'(e.ov));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      failures++;
      checks++;
      $display("FAIL idle_timeout actual=1 required=0");
    end
  endtask

  task automatic op(
    input logic [N-1:0] p,
    input logic [N-1:0] q,
    input logic         b,
    input bit           push
  );
    wait_idle();
    P = p;
    Q = q;
    Bin = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back(model(p, q, b, cyc));
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    P = '0;
    Q = '0;
    Bin = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(DIFF), 32'd0);
    chk("rst_bout", 32'(Bout), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    op(8'd100, 8'd37, 1'b0, 1);
    op(8'd5, 8'd10, 1'b0, 1);
    op(8'd0, 8'd0, 1'b1, 1);
    op(8'hFF, 8'd0, 1'b0, 1);
    op(8'h80, 8'h01, 1'b0, 1);
    op(8'h7F, 8'hFF, 1'b0, 1);

    op(8'd50, 8'd20, 1'b0, 1);
    repeat (2) @(negedge clk);
    P = 8'd1;
    Q = 8'd1;
    Bin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", 32'(busy), 32'd1);

    for (int i = 0; i < 150; i++)
      op(N'($urandom), N'($urandom), 1'($urandom), 1);

    op(8'd200, 8'd3, 1'b0, 0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(DIFF), 32'd0);
    chk("abort_bout", 32'(Bout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd0);
    end

    op(8'h12, 8'h34, 1'b1, 1);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      void'(sb.pop_front());
      checks++;
      failures++;
      $display("FAIL missing_done actual=0 required=1");
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
